// File: rtl/gaussian_filter.sv
// -----------------------------------------------------------------------------
// gaussian_filter
//
// 3x3 Gaussian smoothing of a signed raster stream (kernel [1 2 1; 2 4 2; 1 2 1]
// divided by 16). Only fully populated windows produce an output, so a
// ROWS x COLS input frame yields (ROWS-2) x (COLS-2) outputs in raster order.
// Frames follow one another without any gap.
//
// Optional feature macro: GAUSS_ROUND_EN
//   defined   : result = (sum + 8) >>> 4  (round half toward +inf)
//   undefined : result = sum >>> 4        (truncate toward -inf)
//
// Ports
//   clk               in   single clock, rising edge
//   reset             in   synchronous, active-high
//   pixel_in_TDATA    in   input pixel (signed), raster order
//   pixel_in_TVALID   in   input beat valid
//   pixel_in_TREADY   out  input ready (low while reset or output stalled)
//   pixel_out_TDATA   out  filtered pixel (signed)
//   pixel_out_TVALID  out  output beat valid
//   pixel_out_TREADY  in   downstream ready
// -----------------------------------------------------------------------------
module gaussian_filter #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int ROWS             = 48,
    parameter int COLS             = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
    input  logic                       pixel_in_TVALID,
    output logic                       pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
    output logic                       pixel_out_TVALID,
    input  logic                       pixel_out_TREADY
);

    localparam int PW = PIXEL_BIT_WIDTH;
    localparam int SW = PIXEL_BIT_WIDTH + 4;            // headroom for weight sum of 16
    localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;  // line-buffer address width

    // -------------------------------------------------------------------------
    // Handshake and raster counters
    // -------------------------------------------------------------------------
    logic [IMG_ROW_BITWIDTH-1:0] row_q, row_d;
    logic [IMG_COL_BITWIDTH-1:0] col_q, col_d;
    logic                        accept;
    logic                        win_valid;

    // The output stage is a single register: take a new beat whenever that
    // register is empty or is being drained on this edge.
    assign pixel_in_TREADY = !reset && (!pixel_out_TVALID || pixel_out_TREADY);
    assign accept          = pixel_in_TVALID && pixel_in_TREADY;
    assign win_valid       = (row_q >= IMG_ROW_BITWIDTH'(2)) && (col_q >= IMG_COL_BITWIDTH'(2));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == IMG_COL_BITWIDTH'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == IMG_ROW_BITWIDTH'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    //
    // Reads are registered and addressed by col_d, so the read register always
    // holds the entry for the column about to be accepted. The write on an
    // accept targets col_q while the read targets col_d, which differs from
    // col_q whenever an accept happens, so there is no read/write collision.
    // -------------------------------------------------------------------------
    logic [PW-1:0] lb0_mem [COLS];
    logic [PW-1:0] lb1_mem [COLS];
    logic [PW-1:0] lb0_rd_q;
    logic [PW-1:0] lb1_rd_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_q[AW-1:0]] <= pixel_in_TDATA;
            lb1_mem[col_q[AW-1:0]] <= lb0_rd_q;
        end
        lb0_rd_q <= lb0_mem[col_d[AW-1:0]];
        lb1_rd_q <= lb1_mem[col_d[AW-1:0]];
    end

    // -------------------------------------------------------------------------
    // 3x3 window. Index 0 = row r-2, 1 = row r-1, 2 = row r.
    // Only the two older columns are stored; the newest column is the live
    // {lb1, lb0, pixel} triple, so the sum is formed in the accepting cycle
    // and registered straight into the output stage.
    // -------------------------------------------------------------------------
    logic [2:0][PW-1:0] col_in;
    assign col_in = {pixel_in_TDATA, lb0_rd_q, lb1_rd_q};

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [PW-1:0]        left_q;   // column c-2 at the next accept
        logic [PW-1:0]        mid_q;    // column c-1 at the next accept
        logic signed [SW-1:0] tap_l;
        logic signed [SW-1:0] tap_m;
        logic signed [SW-1:0] tap_r;
        logic signed [SW-1:0] row_sum;  // horizontal [1 2 1] weighting

        always_ff @(posedge clk) begin
            if (reset) begin
                left_q <= '0;
                mid_q  <= '0;
            end else if (accept) begin
                left_q <= mid_q;
                mid_q  <= col_in[gi];
            end
        end

        assign tap_l   = {{4{left_q[PW-1]}}, left_q};
        assign tap_m   = {{4{mid_q[PW-1]}}, mid_q};
        assign tap_r   = {{4{col_in[gi][PW-1]}}, col_in[gi]};
        assign row_sum = tap_l + (tap_m <<< 1) + tap_r;
    end

    // Vertical [1 2 1] weighting of the three row sums gives the full kernel.
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_adj;
    logic [PW-1:0]        result;

    assign sum = g_row[0].row_sum + (g_row[1].row_sum <<< 1) + g_row[2].row_sum;

`ifdef GAUSS_ROUND_EN
    assign sum_adj = sum + SW'(8);
`else
    assign sum_adj = sum;
`endif

    // Weights total 16, so the shifted value always fits in PW bits.
    assign result = PW'(sum_adj >>> 4);

    // -------------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out_TVALID <= 1'b0;
            pixel_out_TDATA  <= '0;
        end else if (accept && win_valid) begin
            pixel_out_TVALID <= 1'b1;
            pixel_out_TDATA  <= result;
        end else if (pixel_out_TREADY) begin
            pixel_out_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gaussian_filter.sv
// -----------------------------------------------------------------------------
// tb_gaussian_filter
//
// Scoreboard bench for gaussian_filter. Before each frame is driven, the
// hand-derived expected output stream is pushed into a queue; an independent
// monitor pops and compares on every output handshake. Output k of a frame
// is centred on input pixel (k/46 + 1, k%46 + 1).
// -----------------------------------------------------------------------------
module tb_gaussian_filter;

    localparam int PW   = 16;
    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int OC   = COLS - 2;
    localparam int NOUT = (ROWS - 2) * (COLS - 2);
    localparam int NPIX = ROWS * COLS;

`ifdef GAUSS_ROUND_EN
    localparam int IMP2_CENTRE = 1;   // (8 + 8) >>> 4
`else
    localparam int IMP2_CENTRE = 0;   // 8 >>> 4
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    gaussian_filter #(
        .PIXEL_BIT_WIDTH (PW),
        .ROWS            (ROWS),
        .COLS            (COLS),
        .IMG_ROW_BITWIDTH(10),
        .IMG_COL_BITWIDTH(10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pixel_in_TDATA  (in_data),
        .pixel_in_TVALID (in_valid),
        .pixel_in_TREADY (in_ready),
        .pixel_out_TDATA (out_data),
        .pixel_out_TVALID(out_valid),
        .pixel_out_TREADY(out_ready)
    );

    int                   checks = 0;
    int                   errors = 0;
    logic signed [PW-1:0] sb[$];
    int                   frame_out = 0;
    int                   rprob = 50;
    bit                   hold_req = 1'b0;
    bit                   hold_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scenarios: 0 const 100, 1 const -3, 2 ramp, 3 impulse 16, 4 impulse 2
    function automatic logic signed [PW-1:0] pix_val(input int scn, input int idx);
        int r;
        int c;
        int v;
        r = idx / COLS;
        c = idx % COLS;
        case (scn)
            0:       v = 100;
            1:       v = -3;
            2:       v = COLS * r + c;
            3:       v = (r == 10 && c == 10) ? 16 : 0;
            4:       v = (r == 10 && c == 10) ? 2 : 0;
            default: v = 0;
        endcase
        return PW'(v);
    endfunction

    function automatic logic signed [PW-1:0] exp_val(input int scn, input int k);
        int r;
        int c;
        int dr;
        int dc;
        int w;
        int v;
        r  = k / OC + 1;
        c  = k % OC + 1;
        dr = (r > 10) ? r - 10 : 10 - r;
        dc = (c > 10) ? c - 10 : 10 - c;
        // centre 4, edge neighbours 2, corners 1 (times 16/16 for impulse 16)
        w  = (dr <= 1 && dc <= 1) ? (2 - dr) * (2 - dc) : 0;
        case (scn)
            0:       v = 100;
            1:       v = -3;
            2:       v = COLS * r + c;
            3:       v = w;
            4:       v = (w == 4) ? IMP2_CENTRE : 0;
            default: v = 0;
        endcase
        return PW'(v);
    endfunction

    // Monitor: output fires on the coming edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            frame_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_output: got %0d, expected no output", $signed(out_data));
            end else begin
                chk("pixel", int'($signed(out_data)), int'(sb.pop_front()));
            end
        end
    end

    // Downstream ready driver, including the 20-cycle stall window.
    task automatic do_hold();
        int w;
        logic [PW-1:0] cap;
        out_ready = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w < 50);
        chk("hold_valid_seen", int'(out_valid), 1);
        cap = out_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'($signed(out_data)), int'($signed(cap)));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        hold_done = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_req && !hold_done) do_hold();
            else out_ready = ($urandom_range(0, 99) < rprob);
        end
    end

    // Drives npix beats of a scenario; entered and left at posedge+2.
    task automatic drive(input int scn, input int npix, input int vprob, input int hold_at);
        int idx;
        int cyc;
        bit pend;
        idx  = 0;
        cyc  = 0;
        pend = 1'b0;
        while (idx < npix) begin
            if (!pend) begin
                if ($urandom_range(0, 99) < vprob) begin
                    in_data  = pix_val(scn, idx);
                    in_valid = 1'b1;
                    pend     = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (hold_at >= 0 && idx == hold_at) hold_req = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                idx++;
                pend = 1'b0;
            end
            @(posedge clk);
            #2;
            cyc++;
            if (cyc > 40000) begin
                $display("FAIL stimulus_timeout: got %0d beats, expected %0d", idx, npix);
                $fatal(1, "input stalled");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input int scn, input int vprob,
                             input int rp, input int hold_at);
        int w;
        rprob     = rp;
        frame_out = 0;
        for (int k = 0; k < NOUT; k++) sb.push_back(exp_val(scn, k));
        drive(scn, NPIX, vprob, hold_at);
        w = 0;
        while (sb.size() != 0 && w < 5000) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #2;
        chk({name, "_drain"}, sb.size(), 0);
        chk({name, "_count"}, frame_out, NOUT);
        $display("frame %s: outputs=%0d", name, frame_out);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'($signed(out_data)), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        run_frame("const100", 0, 50, 50, -1);
        run_frame("const_m3", 1, 50, 50, -1);
        run_frame("ramp", 2, 50, 50, -1);
        // Impulse frames use full-rate input and 75% ready to keep the run short.
        run_frame("impulse16", 3, 100, 75, -1);
        run_frame("impulse2", 4, 100, 75, -1);
        // Full-rate input so the output register is occupied when the stall begins.
        run_frame("hold", 2, 100, 50, 1000);
        chk("hold_done", int'(hold_done), 1);

        // Reset mid-frame after 1000 pixels; the partial frame is discarded.
        rprob = 50;
        for (int k = 0; k < NOUT; k++) sb.push_back(exp_val(0, k));
        drive(0, 1000, 50, -1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'($signed(out_data)), 0);
        chk("midrst_in_ready2", int'(in_ready), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_frame("post_reset", 0, 50, 50, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
